// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor that processes DIGIT bits per clock, LSB digit first.
// The carry is held in a register between slices, and a start/busy/done handshake wraps each operation.
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("serial_addsub: WIDTH must be >= 2 and divisible by DIGIT");
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q, b_q, acc;
   logic             carry;
   logic [SW-1:0]    step;

   logic [DIGIT:0]   slice;
   logic [WIDTH-1:0] acc_next;
   logic             slice_ovf;
   logic             last;

   // NOTE: every signal driven here gets a value before any conditional logic, so no latch can be inferred.
   always_comb begin
      slice    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
      acc_next = acc >> DIGIT;
      acc_next[WIDTH-1 -: DIGIT] = slice[DIGIT-1:0];
      // Signed overflow: the top-bit operands agree in sign but the result bit does not.
      // This is equivalent to carry-into-MSB XOR carry-out.
      slice_ovf = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (slice[DIGIT-1] != a_q[DIGIT-1]);
      last      = (step == SW'(STEPS - 1));
   end

   // NOTE: all state is written with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc      <= '0;
         carry    <= 1'b0;
         step     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // Subtraction is a + ~b + ~borrow_in.
                  a_q   <= a;
                  b_q   <= sub ? ~b : b;
                  carry <= sub ? ~cin : cin;
                  step  <= '0;
                  acc   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               a_q   <= a_q >> DIGIT;
               b_q   <= b_q >> DIGIT;
               acc   <= acc_next;
               carry <= slice[DIGIT];
               step  <= step + 1'b1;
               if (last) begin
                  sum      <= acc_next;
                  cout     <= slice[DIGIT];
                  overflow <= slice_ovf;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub with two instances: DIGIT=1 and DIGIT=4, both WIDTH=8.
// Expected values were computed by hand from the arithmetic definitions.
module tb_serial_addsub;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start1 = 1'b0, start4 = 1'b0;
   logic       sub = 1'b0, cin = 1'b0;
   logic [7:0] a = '0, b = '0;

   logic       busy1, done1, cout1, ovf1;
   logic [7:0] sum1;
   logic       busy4, done4, cout4, ovf4;
   logic [7:0] sum4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(8), .DIGIT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
   );

   serial_addsub #(.WIDTH(8), .DIGIT(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
   );

   task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive operands and pulse start across one rising edge (edge E); return 1 time unit after E.
   task automatic issue(input int d, input logic s, input logic [7:0] av, input logic [7:0] bv, input logic c);
      @(negedge clk);
      sub = s; a = av; b = bv; cin = c;
      if (d == 4) start4 = 1'b1; else start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; start4 = 1'b0;
   endtask

   // Follows a run issued on the previous edge: busy holds for steps-1 edges,
   // done and the results appear after edge E+steps, and done drops one edge later.
   task automatic expect_run(input int d, input string tag, input logic [7:0] es, input logic ec, input logic eo);
      int steps;
      steps = (d == 4) ? 2 : 8;
      check({tag, "_busy_E"}, (d == 4) ? busy4 : busy1, 1'b1);
      for (int k = 1; k < steps; k++) begin
         @(posedge clk); #1;
         check({tag, "_busy_mid"}, (d == 4) ? {busy4, done4} : {busy1, done1}, 2'b10);
      end
      @(posedge clk); #1;
      check({tag, "_done"}, (d == 4) ? {busy4, done4} : {busy1, done1}, 2'b01);
      check({tag, "_sum"},  (d == 4) ? sum4 : sum1, es);
      check({tag, "_cout"}, (d == 4) ? cout4 : cout1, ec);
      check({tag, "_ovf"},  (d == 4) ? ovf4 : ovf1, eo);
      @(posedge clk); #1;
      check({tag, "_done_low"}, (d == 4) ? done4 : done1, 1'b0);
   endtask

   initial begin
      // Reset state.
      #2;
      check("rst_dut1", {busy1, done1, cout1, ovf1, sum1}, 12'h000);
      check("rst_dut4", {busy4, done4, cout4, ovf4, sum4}, 12'h000);
      @(negedge clk); rst = 1'b0;

      // Basic add, add with carry wrap, then the same wrap case on the 4-bit-digit instance.
      issue(1, 1'b0, 8'h0F, 8'h01, 1'b0); expect_run(1, "add_0f_01", 8'h10, 1'b0, 1'b0);
      issue(1, 1'b0, 8'hFF, 8'h01, 1'b1); expect_run(1, "add_wrap",  8'h01, 1'b1, 1'b0);
      issue(4, 1'b0, 8'hFF, 8'h01, 1'b1); expect_run(4, "add_wrap4", 8'h01, 1'b1, 1'b0);

      // Subtraction, with and without a borrow.
      issue(1, 1'b1, 8'h05, 8'h07, 1'b0); expect_run(1, "sub_borrow", 8'hFE, 1'b0, 1'b0);
      issue(1, 1'b1, 8'h07, 8'h05, 1'b1); expect_run(1, "sub_bin",    8'h01, 1'b1, 1'b0);

      // Signed overflow, in both modes and on both instances.
      issue(1, 1'b0, 8'h7F, 8'h01, 1'b0); expect_run(1, "ovf_add",  8'h80, 1'b0, 1'b1);
      issue(1, 1'b1, 8'h80, 8'h01, 1'b0); expect_run(1, "ovf_sub",  8'h7F, 1'b1, 1'b1);
      issue(4, 1'b1, 8'h80, 8'h01, 1'b0); expect_run(4, "ovf_sub4", 8'h7F, 1'b1, 1'b1);

      // A start while busy is ignored, and input changes mid-run have no effect.
      issue(1, 1'b0, 8'h10, 8'h20, 1'b0);
      for (int k = 1; k < 3; k++) begin @(posedge clk); #1; end
      @(negedge clk);
      start1 = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b1; cin = 1'b1;
      @(posedge clk); #1;   // edge E+3
      start1 = 1'b0;
      check("busy_start_sum_held", sum1, 8'h7F);
      for (int k = 4; k < 8; k++) begin @(posedge clk); #1; end
      @(posedge clk); #1;   // edge E+8
      check("hs_done", {busy1, done1}, 2'b01);
      check("hs_sum", sum1, 8'h30);

      // A start in the done cycle is accepted; the old sum holds until the new completion.
      sub = 1'b0; a = 8'h01; b = 8'h01; cin = 1'b0; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      check("bb_busy", {busy1, done1}, 2'b10);
      check("bb_sum_held", sum1, 8'h30);
      for (int k = 1; k < 8; k++) begin @(posedge clk); #1; end
      check("bb_sum_held_late", sum1, 8'h30);
      @(posedge clk); #1;
      check("bb_done", {busy1, done1}, 2'b01);
      check("bb_sum", sum1, 8'h02);
      @(posedge clk); #1;

      // Reset between edges E+3 and E+4 takes effect immediately, and no done pulse follows.
      issue(1, 1'b0, 8'h11, 8'h22, 1'b0);
      for (int k = 1; k < 4; k++) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      check("mid_rst_outputs", {busy1, done1, cout1, ovf1, sum1}, 12'h000);
      @(negedge clk); rst = 1'b0;
      begin
         int seen_done;
         seen_done = 0;
         for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done1 || busy1) seen_done = 1;
         end
         check("mid_rst_no_done", seen_done[0], 1'b0);
      end
      issue(1, 1'b0, 8'h03, 8'h04, 1'b0); expect_run(1, "post_rst", 8'h07, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
